gtx_tx_arbiter: RTL
===================

// Module: gtx_tx_arbiter
// PURPOSE
// - Shares one 16-bit GTX TX lane (2-bit K-char ctrl, 16-bit data) between two word streams.
// - Builds framed bursts: SOF, payload, EOF. Round-robin grant at frame boundaries.
// - Guarantees a K28.5 comma word (16'hbcbc, ctrl 2'b11) at least every COMMA_PERIOD words.
//   Receiver word alignment depends on this.
// - Sits between the channel sources and the GTX TXDATA/TXCHARISK ports.
// PARAMETERS
// - COMMA_PERIOD  16  max words between commas; a comma is forced after COMMA_PERIOD-1 non-comma words.
// - MAX_LEN       64  max payload words per frame (1..255); longer bursts are split.
// PORTS
// - clk_i        in   1   TX user clock
// - rst_n_i      in   1   asynchronous reset, active low
// - ch0_valid_i  in   1   channel 0 word valid
// - ch0_last_i   in   1   channel 0 last word of burst
// - ch0_data_i   in   16  channel 0 payload word
// - ch0_ready_o  out  1   channel 0 word accepted when valid&&ready
// - ch1_valid_i  in   1   channel 1 word valid
// - ch1_last_i   in   1   channel 1 last word of burst
// - ch1_data_i   in   16  channel 1 payload word
// - ch1_ready_o  out  1   channel 1 word accepted when valid&&ready
// - ctrl_o       out  2   K-char flags; bit1 -> data_o[15:8], bit0 -> data_o[7:0]
// - data_o       out  16  lane word
// BEHAVIOUR
// Reset values (asynchronous):
// - ctrl_o=2'b00, data_o=16'h0000, ready_o=0.
// - state=IDLE, prio=ch0, grant=ch0, comma_cnt=0, beat_cnt=0.
// Timing and handshake:
// - ctrl_o/data_o are registered; an accepted beat appears on data_o the next cycle.
// - ready_o is combinational and high only for the granted channel, in PAYLOAD, when no comma is due.
// - ready_o never depends on valid.
// Word codes:
// - COMMA = 16'hbcbc/2'b11.
// - SOF = {8'hfb,7'h00,grant}/2'b10.
// - EOF = {8'hfd,beat_cnt[7:0]}/2'b10.
// - Payload = data word/2'b00.
// Comma counter:
// - comma_cnt counts consecutive non-comma words sent. It clears when a COMMA is sent.
// - due = (comma_cnt == COMMA_PERIOD-1).
// - When due, the next word is COMMA in every state. The state holds, so SOF/EOF are delayed one cycle and ready is low.
// FSM (IDLE, SOF, PAYLOAD, EOF):
// - IDLE
//   - Sends COMMA every cycle.
//   - If any valid: grant = the requesting channel; on a tie, grant = prio. Next state is SOF.
//   - Minimum inter-frame gap is one COMMA.
// - SOF
//   - Sends SOF (unless due), clears beat_cnt, then goes to PAYLOAD.
// - PAYLOAD
//   - On an accepted beat: send the word and beat_cnt++.
//   - Go to EOF if last_i, or if beat_cnt==MAX_LEN-1 (forced split).
//   - After a forced split the remainder arrives as a new frame after arbitration.
//   - Any cycle with no accepted beat (valid low or due) sends COMMA. Frame state and beat_cnt are preserved.
// - EOF
//   - Sends EOF carrying the payload count. beat_cnt reaches 1..MAX_LEN before EOF.
//   - prio becomes the other channel, then IDLE.
// Boundary rules:
// - The non-granted channel never sees ready. Its valid/data may change freely.
// - valid dropping mid-frame does not end the frame; only last_i or MAX_LEN ends it.
// - Reset asserted mid-frame clears immediately: no EOF is sent, and the partial frame is abandoned.
// - Data is not inspected; payload equal to 16'hbcbc is the sources' problem (forbidden).
// TESTING
// 1. Reset, no valid
//    -> ctrl_o/data_o=00/0000 during reset, then 11/bcbc every cycle; both ready low.
// 2. ch0 burst 1111,2222,3333 (last on 3rd), COMMA_PERIOD=16
//    -> bcbc, fb00, 1111, 2222, 3333, fd03; ctrl 11,10,00,00,00,10.
// 3. Both channels valid continuously, 2-word bursts
//    -> frames alternate; SOF fb00, fb01, fb00, ...; ch1 ready never high during a ch0 frame.
// 4. ch0 continuous 70 words, last on 70th, COMMA_PERIOD=16
//    -> after the IDLE comma: SOF + 14 payload, then comma (ready low 1 cycle), then every 15 non-comma words a comma.
//    -> First frame EOF fd40; second frame carries 6 words, EOF fd06.
// 5. ch1 valid toggling 1/0 during payload
//    -> comma on every valid-low cycle; beat_cnt and EOF count reflect accepted beats only.
// 6. rst_n_i low in mid-PAYLOAD
//    -> outputs 00/0000 immediately; after release, IDLE commas resume and ch0 has tie priority.

Source files
------------

// File: rtl/gtx_tx_arbiter.sv
// Two-channel framing arbiter for a 16-bit GTX TX lane.
// Emits SOF/payload/EOF bursts with round-robin grant and periodic K28.5 commas.
module gtx_tx_arbiter #(
    parameter int unsigned COMMA_PERIOD = 16,
    parameter int unsigned MAX_LEN      = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ch0_valid_i,
    input  logic        ch0_last_i,
    input  logic [15:0] ch0_data_i,
    output logic        ch0_ready_o,
    input  logic        ch1_valid_i,
    input  logic        ch1_last_i,
    input  logic [15:0] ch1_data_i,
    output logic        ch1_ready_o,
    output logic [1:0]  ctrl_o,
    output logic [15:0] data_o
);

    localparam int unsigned CntW = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;
    localparam logic [CntW-1:0] DueVal   = CntW'(COMMA_PERIOD - 1);
    localparam logic [7:0]      LastBeat = 8'(MAX_LEN - 1);

    typedef enum logic [1:0] {StIdle, StSof, StPayload, StEof} state_e;

    state_e          state_q, state_d;
    logic            prio_q, prio_d;
    logic            grant_q, grant_d;
    logic [CntW-1:0] comma_cnt_q, comma_cnt_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [15:0]     data_q, data_d;

    logic        due;
    logic        send_comma;
    logic        sel_valid;
    logic        sel_last;
    logic [15:0] sel_data;
    logic        accept;

    assign due       = (comma_cnt_q == DueVal);
    assign sel_valid = grant_q ? ch1_valid_i : ch0_valid_i;
    assign sel_last  = grant_q ? ch1_last_i  : ch0_last_i;
    assign sel_data  = grant_q ? ch1_data_i  : ch0_data_i;

    // Ready is a pure function of state so sources never see a valid->ready loop.
    assign ch0_ready_o = (state_q == StPayload) && !grant_q && !due;
    assign ch1_ready_o = (state_q == StPayload) &&  grant_q && !due;
    assign accept      = (state_q == StPayload) && !due && sel_valid;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        ctrl_d     = 2'b11;
        data_d     = 16'hbcbc;
        send_comma = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (ch0_valid_i || ch1_valid_i) begin
                    grant_d = (ch0_valid_i && ch1_valid_i) ? prio_q : ch1_valid_i;
                    state_d = StSof;
                end
            end
            StSof: begin
                if (!due) begin
                    ctrl_d     = 2'b10;
                    data_d     = {8'hfb, 7'h00, grant_q};
                    send_comma = 1'b0;
                    beat_cnt_d = 8'd0;
                    state_d    = StPayload;
                end
            end
            StPayload: begin
                if (accept) begin
                    ctrl_d     = 2'b00;
                    data_d     = sel_data;
                    send_comma = 1'b0;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (sel_last || (beat_cnt_q == LastBeat)) begin
                        state_d = StEof;
                    end
                end
            end
            StEof: begin
                if (!due) begin
                    ctrl_d     = 2'b10;
                    data_d     = {8'hfd, beat_cnt_q};
                    send_comma = 1'b0;
                    prio_d     = ~grant_q;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        comma_cnt_d = send_comma ? '0 : comma_cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            grant_q     <= 1'b0;
            comma_cnt_q <= '0;
            beat_cnt_q  <= 8'd0;
            ctrl_q      <= 2'b00;
            data_q      <= 16'h0000;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            grant_q     <= grant_d;
            comma_cnt_q <= comma_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule
